// File: rtl/npc_pkg.sv
// Shared NPC core definitions: fetch-unit defaults, FSM state encoding and the
// decode-bound instruction bundle.
package npc_pkg;

  localparam int          IFU_XLEN     = 32;
  localparam logic [31:0] IFU_RESET_PC = 32'h8000_0000;

  typedef enum logic [1:0] {
    S_REQ,
    S_WAIT,
    S_HOLD,
    S_TRAP
  } ifu_state_t;

  typedef struct packed {
    logic [IFU_XLEN-1:0] data;
    logic [IFU_XLEN-1:0] pc;
    logic                misalign;
  } ifu_inst_t;

endpackage

// File: rtl/ifu_pc_reg.sv
// Fetch PC register: reset value, +4 step after a fetched word, redirect load.
module ifu_pc_reg
  import npc_pkg::*;
#(
  parameter int              XLEN     = IFU_XLEN,
  parameter logic [XLEN-1:0] RESET_PC = IFU_RESET_PC
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            inc,
  input  logic            load,
  input  logic [XLEN-1:0] load_pc,
  output logic [XLEN-1:0] pc
);

  logic [XLEN-1:0] pc_reg;

  // A load (redirect) wins over the sequential step.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_reg <= RESET_PC;
    end else if (load) begin
      pc_reg <= load_pc;
    end else if (inc) begin
      pc_reg <= pc_reg + XLEN'(4);
    end
  end

  assign pc = pc_reg;

endmodule

// File: rtl/ifu_fetch.sv
// Instruction fetch unit: one outstanding imem request, stale-response squash on
// redirect. Optional misaligned-redirect trap enabled by IFU_MISALIGN_TRAP_EN.
module ifu_fetch
  import npc_pkg::*;
#(
  parameter int              XLEN     = IFU_XLEN,
  parameter logic [XLEN-1:0] RESET_PC = IFU_RESET_PC
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [XLEN-1:0] inst_data,
  output logic [XLEN-1:0] inst_pc,
`ifdef IFU_MISALIGN_TRAP_EN
  output logic            inst_misalign,
`endif
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc
);

  ifu_state_t      state_reg, state_next;
  logic            drop_reg, drop_next;
  logic            inst_valid_reg, inst_valid_next;
  ifu_inst_t       inst_reg, inst_next;
  logic [XLEN-1:0] fetch_pc;
  logic            pc_inc, pc_load;
  logic            req_fire, outstanding, redirect_trap;

  ifu_pc_reg #(
    .XLEN     (XLEN),
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clk     (clk),
    .rst     (rst),
    .inc     (pc_inc),
    .load    (pc_load),
    .load_pc ({redirect_pc[XLEN-1:2], 2'b00}),
    .pc      (fetch_pc)
  );

  assign req_fire = imem_req_valid && imem_req_ready;
  // A request is still owed a response after this cycle.
  assign outstanding = req_fire || ((state_reg == S_WAIT || drop_reg) && !imem_rsp_valid);

`ifdef IFU_MISALIGN_TRAP_EN
  assign redirect_trap = redirect_valid && (redirect_pc[1:0] != 2'b00);
`else
  assign redirect_trap = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= S_REQ;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    drop_next       = drop_reg;
    inst_valid_next = inst_valid_reg;
    inst_next       = inst_reg;
    pc_inc          = 1'b0;
    pc_load         = 1'b0;
    if (redirect_valid) begin
      // An in-flight response must be waited out and thrown away.
      pc_load         = 1'b1;
      inst_valid_next = 1'b0;
      drop_next       = outstanding;
      state_next      = outstanding ? S_WAIT : S_REQ;
      if (redirect_trap) begin
        state_next      = S_TRAP;
        inst_valid_next = 1'b1;
        inst_next       = '{data: '0, pc: redirect_pc, misalign: 1'b1};
      end
    end else begin
      case (state_reg)
        S_REQ: begin
          if (req_fire) state_next = S_WAIT;
        end
        S_WAIT: begin
          if (imem_rsp_valid) begin
            if (drop_reg) begin
              drop_next  = 1'b0;
              state_next = S_REQ;
            end else begin
              inst_valid_next = 1'b1;
              inst_next       = '{data: imem_rsp_data, pc: fetch_pc, misalign: 1'b0};
              pc_inc          = 1'b1;
              state_next      = S_HOLD;
            end
          end
        end
        S_HOLD: begin
          if (inst_ready) begin
            inst_valid_next = 1'b0;
            state_next      = S_REQ;
          end
        end
        default: begin
          // Trap: present until taken, then idle; absorb a stale response.
          if (inst_ready) inst_valid_next = 1'b0;
          if (imem_rsp_valid) drop_next = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drop_reg       <= 1'b0;
      inst_valid_reg <= 1'b0;
      inst_reg       <= '0;
    end else begin
      drop_reg       <= drop_next;
      inst_valid_reg <= inst_valid_next;
      inst_reg       <= inst_next;
    end
  end

  always_comb begin
    imem_req_valid = 1'b0;
    if (state_reg == S_REQ && !rst) imem_req_valid = 1'b1;
  end

  assign imem_req_addr = fetch_pc;
  assign inst_valid    = inst_valid_reg;
  assign inst_data     = inst_reg.data;
  assign inst_pc       = inst_reg.pc;

`ifdef IFU_MISALIGN_TRAP_EN
  assign inst_misalign = inst_reg.misalign && inst_valid_reg;
`else
  logic misalign_unused;
  logic [1:0] redirect_lsb_unused;
  assign misalign_unused     = inst_reg.misalign;
  assign redirect_lsb_unused = redirect_pc[1:0];
`endif

endmodule

// File: doc/ifu_fetch.md
Name: ifu_fetch

Overview:
- Instruction fetch unit for the NPC core; initiator side of the instruction-memory interface.
- Holds the PC and issues word fetch requests to the instruction ROM/memory.
- Returns fetched instructions, tagged with their PC, to decode over a valid/ready handshake.
- Supports at most one outstanding request and squashes stale responses on a PC redirect from execute.

Parameters:
- RESET_PC, 32'h8000_0000, PC value loaded on reset; first fetch address.
- XLEN, 32, width of PC, address and instruction.

Ports:
- clk  in  1  core clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- imem_req_valid  out  1  fetch request valid.
- imem_req_ready  in  1  memory accepts request this cycle.
- imem_req_addr  out  XLEN  fetch byte address, word aligned.
- imem_rsp_valid  in  1  response data valid; 1 or more cycles after the accepted request.
- imem_rsp_data  in  XLEN  fetched instruction word.
- inst_valid  out  1  instruction available to decode.
- inst_ready  in  1  decode accepts the instruction.
- inst_data  out  XLEN  instruction word.
- inst_pc  out  XLEN  PC of inst_data.
- redirect_valid  in  1  branch/jump taken; restart fetch.
- redirect_pc  in  XLEN  new fetch PC.
- inst_misalign  out  1  present only with IFU_MISALIGN_TRAP_EN.

Behaviour:
- Clock and reset: one clock, clk. Reset is rst: asynchronous, active-high.
- Reset state:
  - pc=RESET_PC, state=S_REQ, drop=0.
  - imem_req_valid=0 during reset, then 1 from the first cycle after deassertion.
  - imem_req_addr=RESET_PC.
  - inst_valid=0, inst_data=0, inst_pc=0, inst_misalign=0.
- Reset mid-operation: any in-flight request is abandoned. An imem_rsp_valid arriving in S_REQ is ignored.
- State S_REQ:
  - Drive imem_req_valid=1 and imem_req_addr=pc.
  - When imem_req_ready=1, the handshake completes; go to S_WAIT.
  - Address is stable while valid and not ready, unless a redirect occurs.
- State S_WAIT:
  - imem_req_valid=0.
  - On imem_rsp_valid with drop=0: latch inst_data=rsp_data and inst_pc=pc, set inst_valid=1, pc<=pc+4 (wraps modulo 2^XLEN), go to S_HOLD.
  - On imem_rsp_valid with drop=1: discard the data, clear drop, go to S_REQ.
- State S_HOLD:
  - inst_valid=1; outputs are stable until inst_ready=1.
  - On accept: inst_valid<=0 and go to S_REQ. The next request is visible the following cycle, so steady-state throughput is 1 instruction per 3 cycles with single-cycle memory.
- Redirect: redirect_valid has priority over every other event in the same cycle; pc<=redirect_pc.
  - S_REQ, no handshake this cycle: stay in S_REQ; the new address appears next cycle.
  - S_REQ, handshake this cycle: the old-address request is in flight; set drop=1, go to S_WAIT.
  - S_WAIT, no rsp this cycle: set drop=1.
  - S_WAIT, rsp this cycle: discard the rsp, go to S_REQ.
  - S_HOLD: clear inst_valid even if inst_ready=1 (instruction squashed), go to S_REQ.
- Alignment: imem_req_addr[1:0] is always 0. Without the optional feature, redirect_pc[1:0] is forced to 0.
- Memory must not assert imem_rsp_valid without a prior accepted request. The unit never has more than one request outstanding.

Optional Feature:
- IFU_MISALIGN_TRAP_EN defined:
  - A redirect with redirect_pc[1:0]!=0 issues no fetch and goes to S_TRAP.
  - S_TRAP presents inst_valid=1, inst_misalign=1, inst_data=0, inst_pc=redirect_pc, held until accepted.
  - After acceptance, the unit stays idle (req_valid=0) until the next redirect.
  - inst_misalign=0 in all other states.
- IFU_MISALIGN_TRAP_EN undefined: no S_TRAP state, no inst_misalign port; low PC bits are truncated.

Decomposition:
- Shared package npc_pkg holds:
  - XLEN and RESET_PC default constants.
  - ifu_state_t enum: S_REQ, S_WAIT, S_HOLD, S_TRAP.
  - A struct {data, pc, misalign} for the decode-bound bundle.
- One natural sub-module: ifu_pc_reg (PC register with reset value, +4 increment, redirect load). The FSM stays in ifu_fetch.

Test Plan:
- Reset release, ready=1, 1-cycle memory returning 32'h00500313 -> first req addr 32'h8000_0000; inst_valid with inst_pc=32'h8000_0000; next req addr 32'h8000_0004.
- imem_req_ready low 3 cycles -> req_valid and addr 32'h8000_0000 held stable; no inst_valid until ready, then rsp.
- inst_ready low 4 cycles in S_HOLD -> inst_data/inst_pc held constant; no new request issued until accept.
- Redirect to 32'h8000_0100 in S_WAIT, rsp 2 cycles later -> rsp discarded, inst_valid stays 0; next req addr 32'h8000_0100.
- Redirect to 32'h8000_0040 same cycle as inst_ready in S_HOLD -> instruction squashed; next req addr 32'h8000_0040.
- With IFU_MISALIGN_TRAP_EN, redirect to 32'h8000_0042 -> no req; inst_valid=1, inst_misalign=1, inst_pc=32'h8000_0042; then idle until next redirect.
